// File: rtl/wb_arbiter.sv
// Two-master, WB_N-slave Wishbone arbiter with round-robin grant.
// A per-transaction watchdog force-terminates cycles that never get acked.
module wb_arbiter #(
  parameter int WB_N    = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          m0_wdata,
  input  logic [15:0]          m0_addr,
  input  logic                 m0_we,
  input  logic [WB_N-1:0]      m0_cyc,
  output logic [31:0]          m0_rdata,
  output logic                 m0_ack,
  input  logic [31:0]          m1_wdata,
  input  logic [15:0]          m1_addr,
  input  logic                 m1_we,
  input  logic [WB_N-1:0]      m1_cyc,
  output logic [31:0]          m1_rdata,
  output logic                 m1_ack,
  output logic [31:0]          s_wdata,
  output logic [15:0]          s_addr,
  output logic                 s_we,
  output logic [WB_N-1:0]      s_cyc,
  input  logic [32*WB_N-1:0]   s_rdata,
  input  logic [WB_N-1:0]      s_ack,
  output logic                 busy,
  output logic                 timeout_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t          state, state_nx;
  logic            owner, owner_nx;
  logic            last_owner, last_nx;
  logic [7:0]      cnt, cnt_nx;
  logic            req0, req1, gnt;
  logic [WB_N-1:0] own_cyc;
  logic [31:0]     rd_or;

  assign req0    = |m0_cyc;
  assign req1    = |m1_cyc;
  // On contention the master that did not win last time gets the bus
  assign gnt     = req1 & (~req0 | ~last_owner);
  assign own_cyc = owner ? m1_cyc : m0_cyc;
  assign busy    = (state == BUSY);

  always_comb begin
    rd_or = '0;
    for (int i = 0; i < WB_N; i++)
      rd_or = rd_or | s_rdata[32*i +: 32];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      cnt        <= 8'd0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      last_owner <= last_nx;
      cnt        <= cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    owner_nx    = owner;
    last_nx     = last_owner;
    cnt_nx      = cnt;
    s_cyc       = '0;
    s_wdata     = m0_wdata;
    s_addr      = m0_addr;
    s_we        = m0_we;
    m0_ack      = 1'b0;
    m1_ack      = 1'b0;
    m0_rdata    = 32'h0;
    m1_rdata    = 32'h0;
    timeout_err = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0 | req1) begin
          state_nx = BUSY;
          owner_nx = gnt;
          last_nx  = gnt;
          cnt_nx   = 8'd0;
        end
      end
      BUSY: begin
        if (owner) begin
          s_wdata = m1_wdata;
          s_addr  = m1_addr;
          s_we    = m1_we;
        end
        if (own_cyc == '0) begin
          state_nx = IDLE;
        end else if (|s_ack) begin
          s_cyc    = own_cyc;
          m0_ack   = ~owner;
          m1_ack   = owner;
          m0_rdata = owner ? 32'h0 : rd_or;
          m1_rdata = owner ? rd_or : 32'h0;
          state_nx = IDLE;
        end else if (cnt == TMO_LAST) begin
          // Forced termination: slaves see cyc drop, owner gets a zero-data ack
          m0_ack      = ~owner;
          m1_ack      = owner;
          timeout_err = 1'b1;
          state_nx    = IDLE;
        end else begin
          s_cyc = own_cyc;
          if (cnt != 8'hFF)
            cnt_nx = cnt + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized bench for wb_arbiter against a transaction-level model.
// Directed scenarios cover read, timeout and mid-transaction reset.
module tb_wb_arbiter;

  localparam int N   = 3;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic [15:0]   m0_addr, m1_addr;
  logic          m0_we, m1_we, m0_ack, m1_ack;
  logic [N-1:0]  m0_cyc, m1_cyc;
  logic [31:0]   s_wdata;
  logic [15:0]   s_addr;
  logic          s_we;
  logic [N-1:0]  s_cyc, s_ack;
  logic [32*N-1:0] s_rdata;
  logic          busy, timeout_err;

  logic [N-1:0]  mcyc[2];
  logic [15:0]   maddr[2];
  logic [31:0]   mwdata[2];
  logic          mwe[2];
  bit            ackd[2];

  int checks = 0;
  int failures = 0;

  // Reference model: who holds the bus and for how many cycles
  bit mb_busy;
  int mb_owner, mb_last, mb_age;

  assign m0_cyc = mcyc[0];
  assign m1_cyc = mcyc[1];
  assign m0_addr = maddr[0];
  assign m1_addr = maddr[1];
  assign m0_wdata = mwdata[0];
  assign m1_wdata = mwdata[1];
  assign m0_we = mwe[0];
  assign m1_we = mwe[1];

  always #5 clk = ~clk;

  wb_arbiter #(.WB_N(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .m0_wdata(m0_wdata), .m0_addr(m0_addr), .m0_we(m0_we),
    .m0_cyc(m0_cyc), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_wdata(m1_wdata), .m1_addr(m1_addr), .m1_we(m1_we),
    .m1_cyc(m1_cyc), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .s_wdata(s_wdata), .s_addr(s_addr), .s_we(s_we),
    .s_cyc(s_cyc), .s_rdata(s_rdata), .s_ack(s_ack),
    .busy(busy), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mb_busy = 0; mb_owner = 0; mb_last = 1; mb_age = 0;
  endtask

  task automatic run_cycle();
    logic [N-1:0] oc, e_cyc;
    logic [31:0]  orr, e_wd, e_rd[2];
    logic [15:0]  e_ad;
    logic         e_we, e_err;
    logic         e_ack[2];
    bit           done;
    #1;
    orr = s_rdata[31:0] | s_rdata[63:32] | s_rdata[95:64];
    e_cyc = '0; e_wd = mwdata[0]; e_ad = maddr[0]; e_we = mwe[0];
    e_ack[0] = 0; e_ack[1] = 0; e_rd[0] = 0; e_rd[1] = 0;
    e_err = 0; done = 0;
    if (mb_busy) begin
      oc = mcyc[mb_owner];
      e_wd = mwdata[mb_owner];
      e_ad = maddr[mb_owner];
      e_we = mwe[mb_owner];
      if (oc == '0) begin
        done = 1;
      end else if (|s_ack) begin
        e_cyc = oc; e_ack[mb_owner] = 1; e_rd[mb_owner] = orr; done = 1;
      end else if (mb_age == TMO - 1) begin
        e_ack[mb_owner] = 1; e_err = 1; done = 1;
      end else begin
        e_cyc = oc;
      end
    end
    chk("busy", busy, mb_busy);
    chk("s_cyc", s_cyc, e_cyc);
    chk("s_wdata", s_wdata, e_wd);
    chk("s_addr", s_addr, e_ad);
    chk("s_we", s_we, e_we);
    chk("m0_ack", m0_ack, e_ack[0]);
    chk("m1_ack", m1_ack, e_ack[1]);
    chk("m0_rdata", m0_rdata, e_rd[0]);
    chk("m1_rdata", m1_rdata, e_rd[1]);
    chk("timeout_err", timeout_err, e_err);
    ackd[0] = e_ack[0];
    ackd[1] = e_ack[1];
    if (!mb_busy) begin
      if (|mcyc[0] || |mcyc[1]) begin
        if (|mcyc[0] && |mcyc[1]) mb_owner = 1 - mb_last;
        else mb_owner = (|mcyc[1]) ? 1 : 0;
        mb_last = mb_owner;
        mb_busy = 1;
        mb_age = 0;
      end
    end else if (done) begin
      mb_busy = 0;
    end else begin
      mb_age++;
    end
    @(posedge clk);
  endtask

  task automatic new_req(input int k);
    mcyc[k] = 3'b001 << $urandom_range(2, 0);
    maddr[k] = 16'($urandom);
    mwdata[k] = $urandom;
    mwe[k] = 1'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      mcyc[k] = '0; maddr[k] = '0; mwdata[k] = '0; mwe[k] = 0; ackd[k] = 0;
    end
    mcyc[0] = 3'b001;
    s_ack = 3'b111;
    s_rdata = {$urandom, $urandom, $urandom};
    model_reset();
    #12;
    chk("rst_s_cyc", s_cyc, 3'b000);
    chk("rst_m0_ack", m0_ack, 1'b0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_m1_rdata", m1_rdata, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tmo", timeout_err, 1'b0);

    // Read from slave 1, acked on the third BUSY cycle
    @(negedge clk);
    rst = 1'b0;
    mcyc[0] = 3'b010; maddr[0] = 16'h0012; mwe[0] = 0;
    s_ack = 0; s_rdata = '0;
    run_cycle();
    @(negedge clk);
    #1 chk("rd_s_cyc", s_cyc, 3'b010);
    run_cycle();
    @(negedge clk);
    run_cycle();
    @(negedge clk);
    s_ack = 3'b010; s_rdata[63:32] = 32'hDEADBEEF;
    #1 chk("rd_m0_ack", m0_ack, 1'b1);
    chk("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("rd_m1_ack", m1_ack, 1'b0);
    run_cycle();
    @(negedge clk);
    mcyc[0] = 0; s_ack = 0; s_rdata = '0;
    #1 chk("rd_idle", busy, 1'b0);
    run_cycle();

    // Master 1 to silent slave 2: forced termination on 4th BUSY cycle
    @(negedge clk);
    mcyc[1] = 3'b100;
    run_cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk("to_s_cyc", s_cyc, 3'b100);
      run_cycle();
    end
    @(negedge clk);
    #1 chk("to_m1_ack", m1_ack, 1'b1);
    chk("to_m1_rdata", m1_rdata, 32'h0);
    chk("to_err", timeout_err, 1'b1);
    chk("to_s_cyc0", s_cyc, 3'b000);
    run_cycle();
    @(negedge clk);
    mcyc[1] = 0;
    run_cycle();

    // Asynchronous reset while master 1 owns the bus
    @(negedge clk);
    mcyc[1] = 3'b001;
    run_cycle();
    @(negedge clk);
    run_cycle();
    @(negedge clk);
    s_ack = 3'b001;
    rst = 1'b1;
    #1 chk("ar_s_cyc", s_cyc, 3'b000);
    chk("ar_m1_ack", m1_ack, 1'b0);
    chk("ar_busy", busy, 1'b0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; s_ack = 0;
    run_cycle();
    @(negedge clk);
    #1 chk("ar_regrant", s_cyc, 3'b001);
    run_cycle();

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (mcyc[k] != '0) begin
          if (ackd[k]) begin
            if ($urandom_range(1, 0) == 0) mcyc[k] = '0;
            else new_req(k);
          end else if ($urandom_range(29, 0) == 0) begin
            mcyc[k] = '0;
          end
        end else if ($urandom_range(2, 0) == 0) begin
          new_req(k);
        end
      end
      s_ack = ($urandom_range(3, 0) == 0) ? 3'b001 << $urandom_range(2, 0)
                                           : 3'b000;
      s_rdata = {$urandom, $urandom, $urandom};
      run_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
